// File: rtl/conveyor_pkg.sv
// Shared types and constants for the packet-size conveyor: flow ids, size records, meter FSM states.
package conveyor_pkg;

    localparam int FLOW_W = 10;

    typedef logic [FLOW_W-1:0] flow_t;
    typedef logic [15:0]       pkt_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } meter_state_e;

    typedef struct packed {
        flow_t     flow;
        pkt_size_t size;
    } size_rec_t;

    localparam pkt_size_t PKT_SIZE_MAX = 16'hFFFF;

endpackage

// File: rtl/meter_fifo.sv
// Small synchronous FIFO holding completed size records until the accumulator can take them.
module meter_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/pkt_size_meter.sv
// Measures the byte length of each packet on a beat stream and emits one size record per packet.
module pkt_size_meter
    import conveyor_pkg::*;
#(
    parameter int A_WIDTH    = 10,
    parameter int DATA_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          in_sop_i,
    input  logic                          in_eop_i,
    input  logic [$clog2(DATA_BYTES)-1:0] in_empty_i,
    input  logic [A_WIDTH-1:0]            in_flow_num_i,
    input  logic                          hold_i,
    output logic [A_WIDTH-1:0]            rx_flow_num_o,
    output logic [15:0]                   pkt_size_o,
    output logic                          pkt_size_en_o,
    output logic [15:0]                   err_cnt_o
);

    localparam int        REC_W     = A_WIDTH + 16;
    localparam int        CW        = $clog2(FIFO_DEPTH) + 1;
    localparam pkt_size_t BEAT_FULL = pkt_size_t'(DATA_BYTES);

    function automatic pkt_size_t sat_add(input pkt_size_t a, input pkt_size_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? PKT_SIZE_MAX : s[15:0];
    endfunction

    meter_state_e         state_q, state_d;
    logic [A_WIDTH-1:0]   flow_q, flow_d;
    pkt_size_t            byte_cnt_q, byte_cnt_d;
    pkt_size_t            err_cnt_q, err_cnt_d;
    logic                 push_q, push_d;
    logic [REC_W-1:0]     push_rec_q, push_rec_d;

    logic                 accept;
    pkt_size_t            beat_bytes;
    logic [REC_W-1:0]     fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic [CW:0]          occupancy;

    logic [A_WIDTH-1:0]   rx_flow_q;
    pkt_size_t            pkt_size_q;
    logic                 pkt_size_en_q;

    // A record staged in push_q is already committed, so it counts against free space.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, push_q};
    assign in_ready_o = !rst_i && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign accept     = in_valid_i && in_ready_o;
    assign beat_bytes = in_eop_i ? (BEAT_FULL - pkt_size_t'(in_empty_i)) : BEAT_FULL;
    assign pop        = !fifo_empty && !hold_i;

    always_comb begin
        state_d    = state_q;
        flow_d     = flow_q;
        byte_cnt_d = byte_cnt_q;
        err_cnt_d  = err_cnt_q;
        push_d     = 1'b0;
        push_rec_d = push_rec_q;
        if (accept) begin
            if (in_sop_i) begin
                // A sop inside a packet abandons it and restarts from this beat.
                if (state_q == IN_PKT) err_cnt_d = sat_add(err_cnt_q, 16'd1);
                if (in_eop_i) begin
                    push_d     = 1'b1;
                    push_rec_d = {in_flow_num_i, beat_bytes};
                    state_d    = IDLE;
                end else begin
                    flow_d     = in_flow_num_i;
                    byte_cnt_d = BEAT_FULL;
                    state_d    = IN_PKT;
                end
            end else if (state_q == IDLE) begin
                err_cnt_d = sat_add(err_cnt_q, 16'd1);
            end else if (in_eop_i) begin
                push_d     = 1'b1;
                push_rec_d = {flow_q, sat_add(byte_cnt_q, beat_bytes)};
                state_d    = IDLE;
            end else begin
                byte_cnt_d = sat_add(byte_cnt_q, BEAT_FULL);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            flow_q     <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
            push_q     <= 1'b0;
            push_rec_q <= '0;
        end else begin
            state_q    <= state_d;
            flow_q     <= flow_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
            push_q     <= push_d;
            push_rec_q <= push_rec_d;
        end
    end

    meter_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_q),
        .push_data_i (push_rec_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Data outputs hold their last record between strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_flow_q     <= '0;
            pkt_size_q    <= '0;
            pkt_size_en_q <= 1'b0;
        end else begin
            pkt_size_en_q <= pop;
            if (pop) begin
                rx_flow_q  <= fifo_head[REC_W-1:16];
                pkt_size_q <= fifo_head[15:0];
            end
        end
    end

    assign rx_flow_num_o = rx_flow_q;
    assign pkt_size_o    = pkt_size_q;
    assign pkt_size_en_o = pkt_size_en_q;
    assign err_cnt_o     = err_cnt_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
